// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC frame assembler.
//  frame_state_t : one-hot lock state (IDLE, SETTLE, RUN, LOST)
//  FCO_PATTERN   : frame-clock word that marks a correctly aligned frame
//  SAMPLE_W      : width of one formatted output sample
//  format_sample : turns a raw 16-bit lane pair into a 16-bit sample
package adc_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        SETTLE = 4'b0010,
        RUN    = 4'b0100,
        LOST   = 4'b1000
    } frame_state_t;

    localparam logic [7:0] FCO_PATTERN = 8'hF0;
    localparam int         SAMPLE_W    = 16;

    // The sample is MSB-justified in the lane pair, so shift it down first.
    // Offset-binary becomes two's complement by flipping its top bit, and
    // the result is then sign-extended across the unused upper bits.
    function automatic logic [SAMPLE_W-1:0] format_sample(
        input logic [SAMPLE_W-1:0] raw,
        input int                  adc_bits,
        input logic                twos_comp
    );
        logic [SAMPLE_W-1:0] s;
        logic [SAMPLE_W-1:0] msb;
        logic [SAMPLE_W-1:0] low_mask;
        s        = raw >> (SAMPLE_W - adc_bits);
        msb      = 16'd1 << (adc_bits - 1);
        low_mask = (msb << 1) - 16'd1;
        if (twos_comp) begin
            s = s ^ msb;
            if ((s & msb) != 16'd0) begin
                s = s | ~low_mask;
            end else begin
                s = s;
            end
        end else begin
            s = s;
        end
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO.
//  CLKDIV  in  clock
//  rst     in  synchronous active-high reset, empties the FIFO
//  wr_en   in  write request; accepted when not full, or when full and a
//              read happens in the same cycle
//  wr_data in  write word
//  rd_en   in  read/pop request; ignored while empty
//  rd_data out head word, valid whenever empty is low (zero while empty)
//  empty   out no words stored
//  count   out number of words stored
module sync_fifo_fwft #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                     CLKDIV,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_s;
    logic             do_wr_s;
    logic             do_rd_s;

    assign full_s  = (count_r == (AW+1)'(DEPTH));
    assign empty   = (count_r == {(AW+1){1'b0}});
    assign do_rd_s = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_wr_s = wr_en & (~full_s | do_rd_s);
    assign rd_data = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
    assign count   = count_r;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge CLKDIV) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge CLKDIV) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/adc_frame_assembler.sv
// Assembles one sample per channel per frame from the ISERDES words once the
// bitslip aligner is locked, buffers them in an FWFT FIFO for an
// AXI-Stream-style sink, and watches FCO for sustained loss of lock.
//  CLKDIV       in  parallel-side clock, one frame per cycle
//  rst          in  synchronous active-high reset
//  aligned      in  lock indication from the aligner
//  ISERDES_FCO  in  frame-clock word
//  lane_a       in  per-channel high byte, ch at [8*ch +: 8]
//  lane_b       in  per-channel low byte, ch at [8*ch +: 8]
//  m_tdata      out samples, ch at [16*ch +: 16]
//  m_tvalid     out output word valid
//  m_tready     in  sink ready
//  lock_ok      out high while in RUN
//  realign_req  out high while in LOST
//  overflow     out sticky, a good frame was dropped on a full FIFO
//  drop_cnt     out saturating count of dropped good frames
module adc_frame_assembler
    import adc_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ADC_BITS    = 14,
    parameter int TWOS_COMP   = 1,
    parameter int SETTLE_CYC  = 16,
    parameter int LOSS_THRESH = 4,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                       CLKDIV,
    input  logic                       rst,
    input  logic                       aligned,
    input  logic [7:0]                 ISERDES_FCO,
    input  logic [8*NUM_CH-1:0]        lane_a,
    input  logic [8*NUM_CH-1:0]        lane_b,
    output logic [SAMPLE_W*NUM_CH-1:0] m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       lock_ok,
    output logic                       realign_req,
    output logic                       overflow,
    output logic [15:0]                drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic                       aligned_r;
    logic [7:0]                 fco_r;
    logic [8*NUM_CH-1:0]        lane_a_r;
    logic [8*NUM_CH-1:0]        lane_b_r;
    logic [SAMPLE_W*NUM_CH-1:0] sample_s;
    frame_state_t               state_r;
    frame_state_t               state_nx_s;
    logic [7:0]                 settle_cnt_r;
    logic [7:0]                 settle_cnt_nx_s;
    logic [3:0]                 bad_cnt_r;
    logic [3:0]                 bad_cnt_nx_s;
    logic                       fco_good_s;
    logic                       wr_en_s;
    logic                       drop_s;
    logic                       fifo_empty_s;
    logic                       fifo_full_s;
    logic [AW:0]                fifo_count_s;
    logic                       lock_ok_r;
    logic                       realign_req_r;
    logic                       overflow_r;
    logic [15:0]                drop_cnt_r;

    // Input stage: one register on every frame-side input.
    always_ff @(posedge CLKDIV) begin
        if (rst) begin
            aligned_r <= 1'b0;
            fco_r     <= 8'h00;
            lane_a_r  <= {(8*NUM_CH){1'b0}};
            lane_b_r  <= {(8*NUM_CH){1'b0}};
        end else begin
            aligned_r <= aligned;
            fco_r     <= ISERDES_FCO;
            lane_a_r  <= lane_a;
            lane_b_r  <= lane_b;
        end
    end

    // Sample formatting for every channel of the registered frame.
    always_comb begin
        sample_s = {(SAMPLE_W*NUM_CH){1'b0}};
        for (int ch = 0; ch < NUM_CH; ch++) begin
            sample_s[SAMPLE_W*ch +: SAMPLE_W] =
                format_sample({lane_a_r[8*ch +: 8], lane_b_r[8*ch +: 8]},
                              ADC_BITS, (TWOS_COMP != 0));
        end
    end

    assign fco_good_s = (fco_r == FCO_PATTERN);

    // Lock FSM next-state logic; loss of aligned always wins over FCO checks.
    always_comb begin
        state_nx_s      = state_r;
        settle_cnt_nx_s = settle_cnt_r;
        bad_cnt_nx_s    = bad_cnt_r;
        wr_en_s         = 1'b0;
        case (state_r)
            IDLE: begin
                bad_cnt_nx_s = 4'd0;
                if (aligned_r) begin
                    state_nx_s      = SETTLE;
                    settle_cnt_nx_s = 8'd0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SETTLE: begin
                if (!aligned_r) begin
                    state_nx_s = IDLE;
                end else if (!fco_good_s) begin
                    state_nx_s = LOST;
                end else if (settle_cnt_r == 8'(SETTLE_CYC - 1)) begin
                    state_nx_s   = RUN;
                    bad_cnt_nx_s = 4'd0;
                end else begin
                    settle_cnt_nx_s = settle_cnt_r + 8'd1;
                end
            end
            RUN: begin
                if (!aligned_r) begin
                    state_nx_s = IDLE;
                end else if (fco_good_s) begin
                    wr_en_s      = 1'b1;
                    bad_cnt_nx_s = 4'd0;
                end else if (bad_cnt_r == 4'(LOSS_THRESH - 1)) begin
                    state_nx_s   = LOST;
                    bad_cnt_nx_s = bad_cnt_r + 4'd1;
                end else begin
                    bad_cnt_nx_s = bad_cnt_r + 4'd1;
                end
            end
            LOST: begin
                if (!aligned_r) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = LOST;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Lock FSM state and status outputs; status follows the next state so
    // it lines up exactly with the state register.
    always_ff @(posedge CLKDIV) begin
        if (rst) begin
            state_r       <= IDLE;
            settle_cnt_r  <= 8'd0;
            bad_cnt_r     <= 4'd0;
            lock_ok_r     <= 1'b0;
            realign_req_r <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            settle_cnt_r  <= settle_cnt_nx_s;
            bad_cnt_r     <= bad_cnt_nx_s;
            lock_ok_r     <= (state_nx_s == RUN);
            realign_req_r <= (state_nx_s == LOST);
        end
    end

    sync_fifo_fwft #(
        .WIDTH (SAMPLE_W*NUM_CH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLKDIV  (CLKDIV),
        .rst     (rst),
        .wr_en   (wr_en_s),
        .wr_data (sample_s),
        .rd_en   (m_tready),
        .rd_data (m_tdata),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    assign fifo_full_s = (fifo_count_s == (AW+1)'(FIFO_DEPTH));
    // A pop in the same cycle makes room, so only a full FIFO without a pop drops.
    assign drop_s      = wr_en_s & fifo_full_s & ~m_tready;

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge CLKDIV) begin
        if (rst) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 16'd0;
        end else begin
            overflow_r <= overflow_r | drop_s;
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign m_tvalid    = ~fifo_empty_s;
    assign lock_ok     = lock_ok_r;
    assign realign_req = realign_req_r;
    assign overflow    = overflow_r;
    assign drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_adc_frame_assembler.sv
module tb_adc_frame_assembler;

    logic        CLKDIV = 1'b0;
    logic        rst;
    logic        aligned;
    logic [7:0]  ISERDES_FCO;
    logic [31:0] lane_a;
    logic [31:0] lane_b;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        lock_ok;
    logic        realign_req;
    logic        overflow;
    logic [15:0] drop_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic        hold_v = 1'b0;
    logic [63:0] hold_d = 64'd0;

    localparam logic [7:0]  GOOD = 8'hF0;
    localparam logic [7:0]  BAD  = 8'hE1;
    localparam logic [31:0] A80  = {4{8'h80}};

    always #5 CLKDIV = ~CLKDIV;

    adc_frame_assembler dut (
        .CLKDIV      (CLKDIV),
        .rst         (rst),
        .aligned     (aligned),
        .ISERDES_FCO (ISERDES_FCO),
        .lane_a      (lane_a),
        .lane_b      (lane_b),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .lock_ok     (lock_ok),
        .realign_req (realign_req),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // lane_a = 8'h80, lane_b = 4*w on every channel gives sample w (w < 64)
    function automatic logic [31:0] lb_of(input int w);
        logic [7:0] b;
        b = 8'(w * 4);
        return {4{b}};
    endfunction

    function automatic logic [63:0] ex_of(input int w);
        logic [15:0] s;
        s = 16'(w);
        return {4{s}};
    endfunction

    // One frame: driven just after a rising edge; expected word queued if written.
    task automatic step(input logic al, input logic [7:0] fco, input logic [31:0] la,
                        input logic [31:0] lb, input logic tr, input logic wr,
                        input logic [63:0] ew);
        @(posedge CLKDIV);
        #1;
        aligned     = al;
        ISERDES_FCO = fco;
        lane_a      = la;
        lane_b      = lb;
        m_tready    = tr;
        if (wr) exp_q.push_back(ew);
    endtask

    // Monitor: pops the scoreboard on every transfer, checks stall stability.
    always @(negedge CLKDIV) begin
        if (rst) begin
            hold_v <= 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", {63'd0, m_tvalid}, 64'd1);
                chk("hold_data", m_tdata, hold_d);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) chk("unexpected_word", m_tdata, 64'hDEAD_DEAD_DEAD_DEAD);
                else chk("word", m_tdata, exp_q.pop_front());
            end
            hold_v <= m_tvalid && !m_tready;
            hold_d <= m_tdata;
        end
    end

    initial begin
        rst = 1'b1; aligned = 1'b0; ISERDES_FCO = 8'h00;
        lane_a = 32'd0; lane_b = 32'd0; m_tready = 1'b1;
        repeat (3) @(posedge CLKDIV);
        #1 rst = 1'b0;
        @(negedge CLKDIV);
        chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("rst_lock", {63'd0, lock_ok}, 64'd0);
        chk("rst_realign", {63'd0, realign_req}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        chk("rst_dropcnt", {48'd0, drop_cnt}, 64'd0);
        chk("rst_tdata", m_tdata, 64'd0);

        // T1: lock-up, 17 frames discarded, then samples
        for (int k = 1; k <= 17; k++) step(1'b1, GOOD, A80, {4{8'h04}}, 1'b1, 1'b0, 64'd0);
        step(1'b1, GOOD, A80, {4{8'h04}}, 1'b1, 1'b1, 64'h0001_0001_0001_0001);
        @(negedge CLKDIV); chk("t1_lock_before", {63'd0, lock_ok}, 64'd0);
        step(1'b1, GOOD, A80, {4{8'h04}}, 1'b1, 1'b1, 64'h0001_0001_0001_0001);
        @(negedge CLKDIV); chk("t1_lock_after", {63'd0, lock_ok}, 64'd1);
        step(1'b1, GOOD, {4{8'h7F}}, {4{8'hFC}}, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b1, GOOD, {4{8'h00}}, {4{8'h00}}, 1'b1, 1'b1, 64'hE000_E000_E000_E000);
        step(1'b1, GOOD, A80, {8'h10, 8'h0C, 8'h08, 8'h04}, 1'b1, 1'b1, 64'h0004_0003_0002_0001);

        // T2a: three bad frames do not lose lock
        for (int k = 0; k < 3; k++) step(1'b1, BAD, A80, lb_of(3), 1'b1, 1'b0, 64'd0);
        step(1'b1, GOOD, A80, lb_of(5), 1'b1, 1'b1, ex_of(5));
        for (int k = 0; k < 2; k++) step(1'b1, BAD, A80, lb_of(3), 1'b1, 1'b0, 64'd0);
        @(negedge CLKDIV);
        chk("t2_still_lock", {63'd0, lock_ok}, 64'd1);
        chk("t2_no_realign", {63'd0, realign_req}, 64'd0);

        // T3: sink stalled for 20 good frames, last four dropped
        for (int j = 0; j < 20; j++) step(1'b1, GOOD, A80, lb_of(32 + j), 1'b0, (j < 16), ex_of(32 + j));
        step(1'b1, BAD, A80, lb_of(3), 1'b0, 1'b0, 64'd0);
        // T4: full FIFO, good frame written in the same cycle as a pop
        step(1'b1, GOOD, A80, lb_of(60), 1'b0, 1'b1, ex_of(60));
        @(negedge CLKDIV);
        chk("t3_overflow", {63'd0, overflow}, 64'd1);
        chk("t3_dropcnt", {48'd0, drop_cnt}, 64'd4);
        chk("t3_tvalid", {63'd0, m_tvalid}, 64'd1);
        step(1'b1, BAD, A80, lb_of(3), 1'b1, 1'b0, 64'd0);
        step(1'b0, GOOD, A80, lb_of(3), 1'b1, 1'b0, 64'd0);
        @(negedge CLKDIV);
        chk("t4_dropcnt", {48'd0, drop_cnt}, 64'd4);
        for (int k = 0; k < 19; k++) step(1'b0, GOOD, A80, lb_of(3), 1'b1, 1'b0, 64'd0);
        @(negedge CLKDIV);
        chk("t3_drained", 64'(exp_q.size()), 64'd0);
        chk("t3_idle_lock", {63'd0, lock_ok}, 64'd0);

        // T6: aligned lost mid-settle, then a full settle again
        for (int k = 0; k < 11; k++) step(1'b1, GOOD, A80, lb_of(9), 1'b1, 1'b0, 64'd0);
        for (int k = 0; k < 2; k++) step(1'b0, GOOD, A80, lb_of(9), 1'b1, 1'b0, 64'd0);
        @(negedge CLKDIV); chk("t6_idle", {63'd0, lock_ok}, 64'd0);
        for (int k = 1; k <= 17; k++) step(1'b1, GOOD, A80, lb_of(9), 1'b1, 1'b0, 64'd0);
        step(1'b1, GOOD, A80, lb_of(7), 1'b1, 1'b1, ex_of(7));
        @(negedge CLKDIV); chk("t6_lock_before", {63'd0, lock_ok}, 64'd0);
        step(1'b1, GOOD, A80, lb_of(8), 1'b1, 1'b1, ex_of(8));
        @(negedge CLKDIV); chk("t6_lock_after", {63'd0, lock_ok}, 64'd1);

        // T2b: four consecutive bad frames -> LOST, then aligned low -> IDLE
        for (int k = 0; k < 4; k++) step(1'b1, BAD, A80, lb_of(3), 1'b1, 1'b0, 64'd0);
        @(negedge CLKDIV); chk("t2_run_lock", {63'd0, lock_ok}, 64'd1);
        step(1'b1, GOOD, A80, lb_of(11), 1'b1, 1'b0, 64'd0);
        @(negedge CLKDIV); chk("t2_realign_pre", {63'd0, realign_req}, 64'd0);
        step(1'b1, GOOD, A80, lb_of(11), 1'b1, 1'b0, 64'd0);
        @(negedge CLKDIV);
        chk("t2_realign", {63'd0, realign_req}, 64'd1);
        chk("t2_lost_lock", {63'd0, lock_ok}, 64'd0);
        step(1'b0, GOOD, A80, lb_of(11), 1'b1, 1'b0, 64'd0);
        step(1'b0, GOOD, A80, lb_of(11), 1'b1, 1'b0, 64'd0);
        @(negedge CLKDIV); chk("t2_realign_hold", {63'd0, realign_req}, 64'd1);
        step(1'b0, GOOD, A80, lb_of(11), 1'b1, 1'b0, 64'd0);
        @(negedge CLKDIV);
        chk("t2_idle_realign", {63'd0, realign_req}, 64'd0);
        chk("t2_idle_lock", {63'd0, lock_ok}, 64'd0);

        // T5: reset with 8 words buffered; the words are never delivered
        for (int k = 1; k <= 17; k++) step(1'b1, GOOD, A80, lb_of(9), 1'b1, 1'b0, 64'd0);
        for (int k = 0; k < 8; k++) step(1'b1, GOOD, A80, lb_of(20 + k), 1'b0, 1'b0, 64'd0);
        step(1'b1, BAD, A80, lb_of(3), 1'b0, 1'b0, 64'd0);
        @(posedge CLKDIV);
        #1 rst = 1'b1;
        @(negedge CLKDIV);
        chk("t5_tvalid_pre", {63'd0, m_tvalid}, 64'd1);
        chk("t5_overflow_pre", {63'd0, overflow}, 64'd1);
        @(posedge CLKDIV);
        #1 rst = 1'b0; aligned = 1'b0; m_tready = 1'b1;
        @(negedge CLKDIV);
        chk("t5_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("t5_lock", {63'd0, lock_ok}, 64'd0);
        chk("t5_realign", {63'd0, realign_req}, 64'd0);
        chk("t5_overflow", {63'd0, overflow}, 64'd0);
        chk("t5_dropcnt", {48'd0, drop_cnt}, 64'd0);
        for (int k = 0; k < 4; k++) step(1'b0, GOOD, A80, lb_of(3), 1'b1, 1'b0, 64'd0);
        @(negedge CLKDIV);
        chk("t5_still_empty", {63'd0, m_tvalid}, 64'd0);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
